// File: rtl/grah8_sequencer.sv
// -----------------------------------------------------------------------------
// grah8_sequencer
//   Fetch/execute controller for the Grah-8 core. The sequencer fetches one
//   instruction byte at a time and classifies it by ir[7:6]:
//     00 immediate  : write {2'b00, ir[5:0]} into reg0
//     01 copy       : reg[ir[2:0]] <= reg[ir[5:3]]. The index IO_SEL stands
//                     for the external byte port, and the copy stalls until
//                     that port is ready.
//     10 calculate  : ALU op ir[2:0], with the result written to reg3
//     11 condition  : jump to reg0 when the condition on signed reg3 holds
//   Every strobe is a single-cycle pulse in the cycle that completes EXEC.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   mem_req/mem_addr    fetch request and address (= pc)
//   mem_ack/mem_data    fetch data valid and instruction byte
//   reg0_val, reg3_val  jump target and condition operand from the register file
//   imm_wr, imm_val     immediate write into reg0
//   rd_sel, wr_sel      copy source and destination indices
//   cpy_wr              register-file write strobe for a copy
//   alu_en, alu_op      ALU execute strobe and operation
//   in_valid, in_take   input-port handshake
//   out_ready, out_put  output-port handshake
//   pc                  current program counter
//   step                single-step pulse (active only with GRAH8_SEQ_STEP_EN)
//
// Configuration
//   GRAH8_SEQ_STEP_EN   When defined, each step pulse allows exactly one
//                       instruction. When undefined, the sequencer free-runs.
//
// Parameters
//   PC_W    address width. Valid range is 6..8, because the jump target
//           comes from the 8-bit reg0.
//   IO_SEL  the copy operand index that selects the I/O port.
// -----------------------------------------------------------------------------
module grah8_sequencer #(
  parameter int PC_W   = 8,
  parameter int IO_SEL = 6
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [7:0]      mem_data,
  input  logic [7:0]      reg0_val,
  input  logic [7:0]      reg3_val,
  output logic            imm_wr,
  output logic [7:0]      imm_val,
  output logic [2:0]      rd_sel,
  output logic [2:0]      wr_sel,
  output logic            cpy_wr,
  output logic            alu_en,
  output logic [2:0]      alu_op,
  input  logic            in_valid,
  output logic            in_take,
  input  logic            out_ready,
  output logic            out_put,
  output logic [PC_W-1:0] pc,
  input  logic            step
);

  localparam logic [2:0] IO_IDX = 3'(IO_SEL);

  typedef enum logic {
    S_FETCH,
    S_EXEC
  } state_t;

  state_t          state, state_nx;
  logic [PC_W-1:0] pc_q, pc_nx;
  logic [7:0]      ir, ir_nx;
  logic            fetch_en;
  logic            src_io, dst_io, exec_done, taken, is_zero, is_neg;

`ifdef GRAH8_SEQ_STEP_EN
  // A step pulse arms exactly one fetch. The flag clears when that fetch
  // is accepted, and pulses that arrive while it is armed are dropped.
  logic step_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        step_pend <= 1'b0;
    else if (state == S_FETCH && step_pend && mem_ack) step_pend <= 1'b0;
    else if (step)                                   step_pend <= 1'b1;
  end

  assign fetch_en = step_pend;
`else
  logic step_unused;
  assign step_unused = step;
  assign fetch_en    = 1'b1;
`endif

  // The field outputs are pure views of ir. Only the strobes qualify them.
  assign imm_val  = {2'b00, ir[5:0]};
  assign rd_sel   = ir[5:3];
  assign wr_sel   = ir[2:0];
  assign alu_op   = ir[2:0];
  assign mem_addr = pc_q;
  assign pc       = pc_q;

  assign src_io  = (ir[5:3] == IO_IDX);
  assign dst_io  = (ir[2:0] == IO_IDX);
  assign is_zero = (reg3_val == 8'h00);
  assign is_neg  = reg3_val[7];

  // A copy that touches the I/O port completes only when every port it
  // uses is ready in the same cycle. All other classes complete at once.
  assign exec_done = (ir[7:6] != 2'b01) ||
                     ((!src_io || in_valid) && (!dst_io || out_ready));

  always_comb begin
    taken = 1'b0;
    unique case (ir[2:0])
      3'd0: taken = 1'b0;
      3'd1: taken = is_zero;
      3'd2: taken = is_neg;
      3'd3: taken = is_zero || is_neg;
      3'd4: taken = 1'b1;
      3'd5: taken = !is_zero;
      3'd6: taken = !is_neg;
      3'd7: taken = !is_zero && !is_neg;
      default: taken = 1'b0;
    endcase
  end

  // NOTE: every output of this block gets a default before the case
  // statement. Without those defaults, any path that skipped an assignment
  // would infer a latch.
  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    ir_nx    = ir;
    mem_req  = 1'b0;
    imm_wr   = 1'b0;
    cpy_wr   = 1'b0;
    alu_en   = 1'b0;
    in_take  = 1'b0;
    out_put  = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req = fetch_en;
        if (fetch_en && mem_ack) begin
          ir_nx    = mem_data;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          state_nx = S_FETCH;
          pc_nx    = pc_q + PC_W'(1);
          unique case (ir[7:6])
            2'b00: imm_wr = 1'b1;
            2'b01: begin
              cpy_wr  = 1'b1;
              in_take = src_io;
              out_put = dst_io;
            end
            2'b10: alu_en = 1'b1;
            2'b11: if (taken) pc_nx = PC_W'(reg0_val);
            default: ;
          endcase
        end
      end
      default: state_nx = S_FETCH;
    endcase
  end

  // NOTE: the state registers use non-blocking assignments only. This
  // keeps every always_ff reading the values from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      pc_q  <= '0;
      ir    <= 8'h00;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
      ir    <= ir_nx;
    end
  end

endmodule

// File: tb/tb_grah8_sequencer.sv
// -----------------------------------------------------------------------------
// tb_grah8_sequencer
//   Scoreboard bench for grah8_sequencer.
//   - The stimulus queues instruction bytes for the memory responder, which
//     acknowledges them in order and checks each fetch address.
//   - For every instruction expected to complete, the stimulus pushes a
//     hand-computed record with the strobes, the fields and the next pc.
//   - The monitor pops a record whenever a strobe fires. When the pc moves
//     without a strobe, it pops a record for a condition instruction.
// -----------------------------------------------------------------------------
module tb_grah8_sequencer;

  localparam logic [4:0] IMM = 5'b10000;
  localparam logic [4:0] CPY = 5'b01000;
  localparam logic [4:0] ALU = 5'b00100;
  localparam logic [4:0] TIN = 5'b00010;
  localparam logic [4:0] PUT = 5'b00001;

  typedef struct {
    logic [4:0] stb;
    logic [7:0] val;
    logic [2:0] a;
    logic [2:0] b;
    logic [7:0] pc_after;
  } rec_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] addr;
    int         waits;
  } feed_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_req, mem_ack;
  logic [7:0] mem_addr, mem_data, reg0_val, reg3_val, imm_val, pc;
  logic [2:0] rd_sel, wr_sel, alu_op;
  logic       imm_wr, cpy_wr, alu_en, in_valid, in_take, out_ready, out_put, step;

  rec_t  exp_q[$];
  feed_t feed[$];
  bit    pending;
  int    n_cmp = 0;
  int    n_err = 0;
  bit    auto_step = 1'b0;

  grah8_sequencer #(.PC_W(8), .IO_SEL(6)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .reg0_val(reg0_val), .reg3_val(reg3_val),
    .imm_wr(imm_wr), .imm_val(imm_val), .rd_sel(rd_sel), .wr_sel(wr_sel),
    .cpy_wr(cpy_wr), .alu_en(alu_en), .alu_op(alu_op),
    .in_valid(in_valid), .in_take(in_take), .out_ready(out_ready), .out_put(out_put),
    .pc(pc), .step(step)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [4:0] s, input logic [7:0] v,
                              input logic [2:0] a, input logic [2:0] b,
                              input logic [7:0] pcn);
    rec_t r;
    r.stb = s; r.val = v; r.a = a; r.b = b; r.pc_after = pcn;
    return r;
  endfunction

  task automatic issue(input logic [7:0] instr, input logic [7:0] addr,
                       input int waits, input rec_t r);
    feed_t f;
    f.data = instr; f.addr = addr; f.waits = waits;
    feed.push_back(f);
    exp_q.push_back(r);
  endtask

  task automatic feed_only(input logic [7:0] instr, input logic [7:0] addr);
    feed_t f;
    f.data = instr; f.addr = addr; f.waits = 0;
    feed.push_back(f);
  endtask

  // Returns aligned to a falling edge so that the caller can drive inputs
  // before the monitor samples.
  task automatic wait_idle(input string name);
    int n = 0;
    while ((feed.size() != 0 || exp_q.size() != 0 || pending) && n < 200) begin
      @(negedge clk); #3;
      n++;
    end
    check({name, "_idle_bound"}, 32'(n < 200), 32'd1);
    @(negedge clk);
  endtask

  // Memory responder: it acknowledges queued bytes after the requested
  // number of wait cycles.
  initial begin
    int wcnt = 0;
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else if (feed.size() != 0 && mem_req) begin
        if (wcnt < feed[0].waits) begin
          mem_ack = 1'b0;
          wcnt++;
        end else begin
          mem_ack  = 1'b1;
          mem_data = feed[0].data;
          check("fetch_addr", 32'(mem_addr), 32'(feed[0].addr));
          void'(feed.pop_front());
          wcnt = 0;
        end
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

`ifdef GRAH8_SEQ_STEP_EN
  initial begin
    step = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_step) step = (feed.size() != 0);
    end
  end
`else
  initial step = 1'b0;
`endif

  // Monitor: pops and compares one record per completed instruction.
  initial begin
    logic [4:0] stb;
    logic [7:0] last_pc = 8'h00;
    logic [7:0] pend_pc = 8'h00;
    rec_t       r;
    pending = 1'b0;
    forever begin
      @(negedge clk); #2;
      stb = {imm_wr, cpy_wr, alu_en, in_take, out_put};
      if (!rst) begin
        pending = 1'b0;
        last_pc = pc;
      end else begin
        if (pending) begin
          check("pc_after", 32'(pc), 32'(pend_pc));
          pending = 1'b0;
        end else if (pc != last_pc) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pc_move", 32'(pc), 32'(last_pc));
          end else begin
            r = exp_q.pop_front();
            check("jump_kind", 32'(r.stb), 32'd0);
            check("jump_pc", 32'(pc), 32'(r.pc_after));
          end
        end
        if (stb != 5'd0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'(stb), 32'd0);
          end else begin
            r = exp_q.pop_front();
            check("strobes", 32'(stb), 32'(r.stb));
            if (r.stb[4]) check("imm_val", 32'(imm_val), 32'(r.val));
            if (r.stb[3]) begin
              check("rd_sel", 32'(rd_sel), 32'(r.a));
              check("wr_sel", 32'(wr_sel), 32'(r.b));
            end
            if (r.stb[2]) check("alu_op", 32'(alu_op), 32'(r.a));
            pend_pc = r.pc_after;
            pending = 1'b1;
          end
        end
        last_pc = pc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    reg0_val = 8'h00; reg3_val = 8'h00;
    repeat (2) @(negedge clk);
    #2;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_strobes", 32'({imm_wr, cpy_wr, alu_en, in_take, out_put}), 32'd0);

`ifdef GRAH8_SEQ_STEP_EN
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) begin
      @(negedge clk); #2;
      check("no_step_req", 32'(mem_req), 32'd0);
    end
    issue(8'h00, 8'h00, 0, mk(IMM, 8'h00, 3'd0, 3'd0, 8'h01));
    issue(8'h00, 8'h01, 0, mk(IMM, 8'h00, 3'd0, 3'd0, 8'h02));
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    repeat (12) @(negedge clk);
    #3;
    check("one_step_exp", 32'(exp_q.size()), 32'd1);
    check("one_step_feed", 32'(feed.size()), 32'd1);
    check("one_step_pc", 32'(pc), 32'd1);
    @(negedge clk); auto_step = 1'b1;
    wait_idle("step");
`else
    // Zero-wait memory: one instruction every two cycles.
    issue(8'h00, 8'h00, 0, mk(IMM, 8'h00, 3'd0, 3'd0, 8'h01));
    issue(8'h00, 8'h01, 0, mk(IMM, 8'h00, 3'd0, 3'd0, 8'h02));
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); #2;
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    #2;
    check("pc_c3", 32'(pc), 32'd1);
    repeat (2) @(negedge clk);
    #2;
    check("pc_c5", 32'(pc), 32'd2);
    wait_idle("t1");
`endif

    // Immediate, then a copy to the output port with a 3-cycle stall.
    issue(8'h05, 8'h02, 0, mk(IMM, 8'h05, 3'd0, 3'd0, 8'h03));
    issue(8'h46, 8'h03, 1, mk(CPY | PUT, 8'h00, 3'd0, 3'd6, 8'h04));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 1 && !mem_req && feed.size() == 0) && n < 100);
    check("stall_reach_bound", 32'(n < 100), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #2;
      check("stall_cpy", 32'({cpy_wr, out_put}), 32'd0);
      check("stall_pc", 32'(pc), 32'd3);
    end
    @(negedge clk); out_ready = 1'b1;
    wait_idle("t2");
    out_ready = 1'b0;

    // Copy from the input port, a copy with both operands on I/O, and index 7.
    in_valid = 1'b1;
    issue(8'h70, 8'h04, 0, mk(CPY | TIN, 8'h00, 3'd6, 3'd0, 8'h05));
    wait_idle("cin");
    out_ready = 1'b1;
    issue(8'h76, 8'h05, 0, mk(CPY | TIN | PUT, 8'h00, 3'd6, 3'd6, 8'h06));
    wait_idle("cboth");
    in_valid = 1'b0; out_ready = 1'b0;
    issue(8'h7F, 8'h06, 2, mk(CPY, 8'h00, 3'd7, 3'd7, 8'h07));
    wait_idle("c77");

    // ALU instruction.
    issue(8'h85, 8'h07, 0, mk(ALU, 8'h00, 3'd5, 3'd0, 8'h08));
    wait_idle("alu");

    // Conditions.
    reg0_val = 8'h10;
    issue(8'hC4, 8'h08, 0, mk(5'd0, 8'h00, 3'd0, 3'd0, 8'h10));
    wait_idle("always");
    reg3_val = 8'h01;
    issue(8'hC1, 8'h10, 0, mk(5'd0, 8'h00, 3'd0, 3'd0, 8'h11));
    wait_idle("eqz_nt");
    reg0_val = 8'h20; reg3_val = 8'h80;
    issue(8'hC2, 8'h11, 0, mk(5'd0, 8'h00, 3'd0, 3'd0, 8'h20));
    wait_idle("ltz_t");
    issue(8'hC0, 8'h20, 0, mk(5'd0, 8'h00, 3'd0, 3'd0, 8'h21));
    wait_idle("never");
    reg3_val = 8'h00;
    issue(8'hC7, 8'h21, 0, mk(5'd0, 8'h00, 3'd0, 3'd0, 8'h22));
    wait_idle("gtz_nt");
    reg0_val = 8'h30;
    issue(8'hC3, 8'h22, 0, mk(5'd0, 8'h00, 3'd0, 3'd0, 8'h30));
    wait_idle("lez_t");
    reg3_val = 8'hFF;
    issue(8'hC6, 8'h30, 0, mk(5'd0, 8'h00, 3'd0, 3'd0, 8'h31));
    wait_idle("gez_nt");
    reg0_val = 8'hFF; reg3_val = 8'h7F;
    issue(8'hC5, 8'h31, 0, mk(5'd0, 8'h00, 3'd0, 3'd0, 8'hFF));
    wait_idle("nez_t");

    // ALU at pc 0xFF: pc wraps to 0.
    issue(8'h81, 8'hFF, 0, mk(ALU, 8'h00, 3'd1, 3'd0, 8'h00));
    wait_idle("wrap");

    // Reset during an I/O stall.
    issue(8'h01, 8'h00, 0, mk(IMM, 8'h01, 3'd0, 3'd0, 8'h01));
    wait_idle("pre_rst");
    feed_only(8'h46, 8'h01);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(!mem_req && feed.size() == 0) && n < 100);
    check("rst_stall_bound", 32'(n < 100), 32'd1);
    @(negedge clk); rst = 1'b0;
    #2;
    check("rst_mid_strobes", 32'({imm_wr, cpy_wr, alu_en, in_take, out_put}), 32'd0);
    check("rst_mid_pc", 32'(pc), 32'd0);
    out_ready = 1'b1; in_valid = 1'b1;
    #1;
    check("rst_hold_strobes", 32'({imm_wr, cpy_wr, alu_en, in_take, out_put}), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    issue(8'h3F, 8'h00, 0, mk(IMM, 8'h3F, 3'd0, 3'd0, 8'h01));
    wait_idle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
